alu_seq: RTL and testbench

Registered, handshaked ALU with a parametrised datapath width, sitting between the register-file read stage and the write-back stage of the core. It extends the earlier combinational ALU with shifts, a signed-overflow flag, borrow-correct subtraction flags and an optional iterative multiplier. Operands enter on a valid/ready handshake and results leave on a second valid/ready handshake. Single-cycle operations can sustain one result per clock.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 52 +++++
 rtl/alu_seq.sv | 157 +++++++++++++++
 tb/tb_alu_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared ALU constants: opcodes, flag bit positions and controller state encodings.
// No logic; imported by alu_seq and its multiplier.
// Flag vector layout is {N,Z,C,V} on both psr and apsr.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  localparam int APSR_NEG   = 3;
  localparam int APSR_ZERO  = 2;
  localparam int APSR_CARRY = 1;
  localparam int APSR_OVF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier, one partial product per cycle.
// Latency: start pulse, then DATA_WIDTH cycles; done is high on the last step cycle.
// No backpressure: product is combinational and only meaningful while done is high.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           cnt;
  logic                    running;

  // product folds in the current step so the caller can capture it on done
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = running && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{DATA_WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= CW'(DATA_WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      acc     <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt - 1'b1;
      if (cnt == '0) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready in and out; optional iterative MUL under ALU_SEQ_MUL_EN.
// Latency: 1 cycle for single-cycle ops, DATA_WIDTH+1 for MUL.
// Backpressure: result held while out_ready is low; in_ready = IDLE, or HOLD with out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   operation,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            psr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            apsr
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  state_t state, state_nxt;
  logic                  accept;
  logic                  alu_load;
  logic                  cin;
  logic [SHW-1:0]        sh_amt;
  logic [DATA_WIDTH:0]   add_w, sub_w, shl_w, shr_w, asr_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c, alu_v, alu_pass;
  logic [3:0]            alu_flags;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);

  assign sh_amt = b_i[SHW-1:0];
  assign cin    = ((operation == OP_WIDTH'(OP_ADDC)) || (operation == OP_WIDTH'(OP_SUBC)))
                  ? psr[APSR_CARRY] : 1'b0;

  // one extra bit catches carry/borrow; shifts keep the last bit out in the extra bit
  assign add_w = {1'b0, a_i} + {1'b0, b_i} + {{DATA_WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i} - {{DATA_WIDTH{1'b0}}, cin};
  assign shl_w = {1'b0, a_i} << sh_amt;
  assign shr_w = {a_i, 1'b0} >> sh_amt;
  assign asr_w = $unsigned($signed({a_i, 1'b0}) >>> sh_amt);

  always_comb begin
    alu_res  = a_i;
    alu_c    = 1'b0;
    alu_v    = psr[APSR_OVF];
    alu_pass = 1'b0;
    case (operation)
      OP_WIDTH'(OP_ADD), OP_WIDTH'(OP_ADDC): begin
        alu_res = add_w[MSB:0];
        alu_c   = add_w[DATA_WIDTH];
        alu_v   = (a_i[MSB] == b_i[MSB]) && (add_w[MSB] != a_i[MSB]);
      end
      OP_WIDTH'(OP_SUB), OP_WIDTH'(OP_SUBC): begin
        alu_res = sub_w[MSB:0];
        alu_c   = sub_w[DATA_WIDTH];
        alu_v   = (a_i[MSB] != b_i[MSB]) && (sub_w[MSB] != a_i[MSB]);
      end
      OP_WIDTH'(OP_NAND): alu_res = ~(a_i & b_i);
      OP_WIDTH'(OP_NOR):  alu_res = ~(a_i | b_i);
      OP_WIDTH'(OP_XOR):  alu_res = a_i ^ b_i;
      OP_WIDTH'(OP_XNOR): alu_res = ~(a_i ^ b_i);
      OP_WIDTH'(OP_SHL): begin
        alu_res = shl_w[MSB:0];
        alu_c   = (sh_amt == '0) ? psr[APSR_CARRY] : shl_w[DATA_WIDTH];
      end
      OP_WIDTH'(OP_SHR): begin
        alu_res = shr_w[DATA_WIDTH:1];
        alu_c   = (sh_amt == '0) ? psr[APSR_CARRY] : shr_w[0];
      end
      OP_WIDTH'(OP_ASR): begin
        alu_res = asr_w[DATA_WIDTH:1];
        alu_c   = (sh_amt == '0) ? psr[APSR_CARRY] : asr_w[0];
      end
      default: alu_pass = 1'b1;
    endcase
    alu_flags = alu_pass ? psr : {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
  end

`ifdef ALU_SEQ_MUL_EN
  logic                    is_mul;
  logic                    mul_start;
  logic                    mul_done;
  logic                    mul_v;
  logic [2*DATA_WIDTH-1:0] mul_prod;

  assign is_mul    = (operation == OP_WIDTH'(OP_MUL));
  assign mul_start = accept && is_mul;
  assign alu_load  = accept && !is_mul;
  assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_i),
    .b       (b_i),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign alu_load = accept;
  assign in_ready = !rst && (!out_valid || out_ready);
`endif

  always_comb begin
    state_nxt = state;
    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      state_nxt = is_mul ? ST_BUSY : ST_HOLD;
`else
      state_nxt = ST_HOLD;
`endif
    end else if ((state == ST_HOLD) && out_ready) begin
      state_nxt = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
    end else if ((state == ST_BUSY) && mul_done) begin
      state_nxt = ST_HOLD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      result <= '0;
      apsr   <= '0;
`ifdef ALU_SEQ_MUL_EN
      mul_v  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (alu_load) begin
        result <= alu_res;
        apsr   <= alu_flags;
      end
`ifdef ALU_SEQ_MUL_EN
      // psr is only valid on the accept cycle, so V is kept for completion
      if (mul_start) mul_v <= psr[APSR_OVF];
      if ((state == ST_BUSY) && mul_done) begin
        result <= mul_prod[MSB:0];
        apsr   <= {mul_prod[MSB], (mul_prod[MSB:0] == '0),
                   (mul_prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0), mul_v};
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus randomized ops scored against an integer reference model.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic [3:0]  psr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  apsr;

  int checks = 0;
  int errors = 0;

  logic [19:0] sbq[$];
  logic        hold_prev;
  logic [19:0] held;

  alu_seq #(.DATA_WIDTH(16), .OP_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a_i       (a_i),
    .b_i       (b_i),
    .psr       (psr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .apsr      (apsr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: flags from true integer results, returns {N,Z,C,V,result}
  function automatic logic [19:0] ref_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [3:0] p);
    logic [15:0] rr;
    logic        c, v;
    int          sh, cin, sa, sb, t;
    longint      s;
    rr  = a;
    c   = 1'b0;
    v   = p[0];
    sh  = int'(b[3:0]);
    cin = (op == 4'd1 || op == 4'd3) ? int'(p[1]) : 0;
    sa  = $signed(a);
    sb  = $signed(b);
    case (op)
      4'd0, 4'd1: begin
        s  = longint'(a) + longint'(b) + longint'(cin);
        rr = s[15:0];
        c  = (s > 65535);
        t  = sa + sb + cin;
        v  = (t > 32767) || (t < -32768);
      end
      4'd2, 4'd3: begin
        s  = longint'(a) - longint'(b) - longint'(cin);
        rr = s[15:0];
        c  = (s < 0);
        t  = sa - sb - cin;
        v  = (t > 32767) || (t < -32768);
      end
      4'd4: rr = ~(a & b);
      4'd5: rr = ~(a | b);
      4'd6: rr = a ^ b;
      4'd7: rr = ~(a ^ b);
      4'd8: begin
        rr = a << sh;
        c  = (sh == 0) ? p[1] : a[16 - sh];
      end
      4'd9: begin
        rr = a >> sh;
        c  = (sh == 0) ? p[1] : a[sh - 1];
      end
      4'd10: begin
        rr = 16'(sa >>> sh);
        c  = (sh == 0) ? p[1] : a[sh - 1];
      end
`ifdef ALU_SEQ_MUL_EN
      4'd11: begin
        s  = longint'(a) * longint'(b);
        rr = s[15:0];
        c  = (s[31:16] != 16'h0);
        v  = p[0];
      end
`endif
      default: return {p, a};
    endcase
    return {rr[15], (rr == 16'h0), c, v, rr};
  endfunction

  // Scoreboard: push at accept, pop at output handshake, and watch held outputs
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", {out_valid, apsr, result}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_unexpected_output", 32'(sbq.size()), 32'd1);
        else chk("sb_result", {apsr, result}, sbq.pop_front());
      end
      if (in_valid && in_ready) sbq.push_back(ref_model(operation, a_i, b_i, psr));
      hold_prev = out_valid && !out_ready;
      held      = {apsr, result};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] p, input bit rnd_rdy);
    int n;
    n = 0;
    in_valid  = 1'b1;
    operation = op;
    a_i       = a;
    b_i       = b;
    psr       = p;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
      step();
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    in_valid = 1'b0;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_out(input string name, input logic [15:0] r, input logic [3:0] f);
    @(negedge clk);
    chk({name, "_vld"}, out_valid, 1'b1);
    chk({name, "_res"}, result, r);
    chk({name, "_flags"}, apsr, f);
    step();
  endtask

  initial begin
    int busy;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    operation = 4'd0;
    a_i       = 16'h0;
    b_i       = 16'h0;
    psr       = 4'h0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0);
    chk("rst_apsr", apsr, 4'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    step();

    issue(4'd0, 16'hFFFF, 16'h0001, 4'h0, 1'b0);
    check_out("add_wrap", 16'h0000, 4'b0110);
    issue(4'd2, 16'h0005, 16'h0007, 4'h0, 1'b0);
    check_out("sub_borrow", 16'hFFFE, 4'b1010);
    issue(4'd2, 16'h8000, 16'h0001, 4'h0, 1'b0);
    check_out("sub_ovf", 16'h7FFF, 4'b0001);
    issue(4'd10, 16'h8003, 16'h0001, 4'h0, 1'b0);
    check_out("asr", 16'hC001, 4'b1010);
    issue(4'd8, 16'h1234, 16'h0010, 4'b0010, 1'b0);
    check_out("shl_zero", 16'h1234, 4'b0010);

`ifdef ALU_SEQ_MUL_EN
    issue(4'd11, 16'h0100, 16'h0300, 4'h0, 1'b0);
    busy = 0;
    n    = 0;
    while (n < 100) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) busy++;
      n++;
      step();
    end
    chk("mul_busy_cycles", 32'(busy), 32'd16);
    chk("mul_latency", 32'(n + 1), 32'd17);
    chk("mul_res", result, 16'h0000);
    chk("mul_flags", apsr, 4'b0110);
    step();
`else
    issue(4'd11, 16'hA5C3, 16'h0300, 4'b1011, 1'b0);
    check_out("op11_pass", 16'hA5C3, 4'b1011);
`endif

    // Backpressure with an XOR waiting behind the held result
    out_ready = 1'b0;
    issue(4'd4, 16'h0F0F, 16'h00FF, 4'h0, 1'b0);
    in_valid  = 1'b1;
    operation = 4'd6;
    a_i       = 16'h0F0F;
    b_i       = 16'h00FF;
    psr       = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_result", result, 16'hFFF0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_vld", out_valid, 1'b1);
    chk("bp_next_res", result, 16'h0FF0);
    step();

    // Reset in the middle of an operation
`ifdef ALU_SEQ_MUL_EN
    issue(4'd11, 16'h1234, 16'h0056, 4'h0, 1'b0);
`else
    out_ready = 1'b0;
    issue(4'd0, 16'h0001, 16'h0002, 4'h0, 1'b0);
`endif
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result", result, 16'h0);
    chk("abort_apsr", apsr, 4'h0);
    chk("abort_in_ready", in_ready, 1'b1);
    step();
    issue(4'd0, 16'h1234, 16'h4321, 4'h0, 1'b0);
    check_out("after_abort_add", 16'h5555, 4'b0000);

    // Randomized traffic with random backpressure, scored by the monitor
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom), 1'b1);
    end

    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      step();
      n++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
